// File: rtl/xm_mem_pkg.sv
// Shared types and constants for the X-Makina memory-side responder.
// The address width follows the processor's byte-addressed MAR, with one bit dropped to form a word address.
package xm_mem_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = WORD_W - (WORD_W / 8) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_LO   = 2'b01;

  function automatic logic [1:0] be_sel(input logic byte_op, input logic byte_hi);
    if (!byte_op) return BE_WORD;
    return byte_hi ? BE_HI : BE_LO;
  endfunction

endpackage

// File: rtl/xm_wait_counter.sv
// Loadable 4-bit down-counter that times SRAM wait states.
// It stops at zero instead of wrapping.
module xm_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst)                      count <= 4'd0;
    else if (load)                count <= load_val;
    else if (en && count != 4'd0) count <= count - 4'd1;
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/xm_memory_controller.sv
// Memory-side responder: takes datapath requests, runs one SRAM access with wait states, and answers with a ready pulse.
// Handshake: req_i is sampled only in IDLE; ready_o is a one-cycle pulse carrying rdata_o/err_o, and the requester re-issues after it.
module xm_memory_controller
  import xm_mem_pkg::*;
#(
  parameter int unsigned       WORD       = 16,
  parameter int unsigned       WAIT       = 2,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 15'h7FFF
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              req_i,
  input  logic              wr_i,
  input  logic              byteOp_i,
  input  logic              byteHi_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD-1:0]   wdata_i,
  output logic [WORD-1:0]   rdata_o,
  output logic              ready_o,
  output logic              err_o,
  output logic              sram_cs_o,
  output logic              sram_we_o,
  output logic [1:0]        sram_be_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [WORD-1:0]   sram_wdata_o,
  input  logic [WORD-1:0]   sram_rdata_i,
  output logic [1:0]        dbg_state
);

  state_t              state, next_state;
  logic                wr_q, byte_q, hi_q, err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD-1:0]     wdata_q, rdata_q, steered;
  logic                accept, bad_addr, cnt_zero;

  assign accept   = (state == IDLE) && req_i;
  assign bad_addr = (addr_i > ADDR_LIMIT);
  assign dbg_state = state;

  xm_wait_counter u_wait (
    .clk      (clk_i),
    .rst      (arst_i),
    .load     (accept && !bad_addr),
    .en       (state == ACCESS),
    .load_val (4'(WAIT)),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk_i) begin
    if (arst_i) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_i) next_state = bad_addr ? RESP : ACCESS;
      ACCESS:  if (cnt_zero) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Byte reads return the selected lane zero-extended into the low byte.
  always_comb begin
    steered = sram_rdata_i;
    if (byte_q)
      steered = {{(WORD-8){1'b0}}, hi_q ? sram_rdata_i[WORD-1 -: 8] : sram_rdata_i[7:0]};
  end

  // rdata_q is cleared on accept so writes and errors answer with zero.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      hi_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      wr_q    <= wr_i;
      byte_q  <= byteOp_i;
      hi_q    <= byteHi_i;
      err_q   <= bad_addr;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      rdata_q <= '0;
    end else if (state == ACCESS && cnt_zero && !wr_q) begin
      rdata_q <= steered;
    end
  end

  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_be_o    = 2'b00;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    ready_o      = 1'b0;
    rdata_o      = '0;
    err_o        = 1'b0;
    case (state)
      ACCESS: begin
        sram_cs_o    = 1'b1;
        sram_we_o    = wr_q;
        sram_be_o    = be_sel(byte_q, hi_q);
        sram_addr_o  = addr_q;
        sram_wdata_o = wdata_q;
      end
      RESP: begin
        ready_o = 1'b1;
        rdata_o = rdata_q;
        err_o   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_xm_memory_controller.sv
// Directed bench for xm_memory_controller: one instance with WAIT=2 and a reduced address limit, one with WAIT=0 for throughput.
module tb_xm_memory_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- DUT A: WAIT=2, ADDR_LIMIT=0x0FFF ----------------
  logic        a_rst = 1'b1, a_req = 1'b0, a_wr = 1'b0, a_bo = 1'b0, a_hi = 1'b0;
  logic [14:0] a_addr = '0;
  logic [15:0] a_wdata = '0;
  logic [15:0] a_rdata, a_swdata;
  logic [15:0] a_srdata = '0;
  logic        a_ready, a_err, a_cs, a_we;
  logic [1:0]  a_be, a_dbg;
  logic [14:0] a_saddr;
  logic [15:0] mem_a [0:255];

  xm_memory_controller #(.WORD(16), .WAIT(2), .ADDR_LIMIT(15'h0FFF)) dut_a (
    .clk_i(clk), .arst_i(a_rst), .req_i(a_req), .wr_i(a_wr), .byteOp_i(a_bo),
    .byteHi_i(a_hi), .addr_i(a_addr), .wdata_i(a_wdata), .rdata_o(a_rdata),
    .ready_o(a_ready), .err_o(a_err), .sram_cs_o(a_cs), .sram_we_o(a_we),
    .sram_be_o(a_be), .sram_addr_o(a_saddr), .sram_wdata_o(a_swdata),
    .sram_rdata_i(a_srdata), .dbg_state(a_dbg)
  );

  // Synchronous SRAM model: byte-enabled write, registered read data.
  always @(posedge clk) begin
    if (a_cs) begin
      if (a_we && a_be[1]) mem_a[a_saddr[7:0]][15:8] <= a_swdata[15:8];
      if (a_we && a_be[0]) mem_a[a_saddr[7:0]][7:0]  <= a_swdata[7:0];
      a_srdata <= mem_a[a_saddr[7:0]];
    end
  end

  // ---------------- DUT B: WAIT=0, default limit ----------------
  logic        b_rst = 1'b1, b_req = 1'b0;
  logic [15:0] b_rdata, b_swdata;
  logic        b_ready, b_err, b_cs, b_we;
  logic [1:0]  b_be, b_dbg;
  logic [14:0] b_saddr;

  xm_memory_controller #(.WORD(16), .WAIT(0)) dut_b (
    .clk_i(clk), .arst_i(b_rst), .req_i(b_req), .wr_i(1'b0), .byteOp_i(1'b0),
    .byteHi_i(1'b0), .addr_i(15'h0042), .wdata_i(16'h0000), .rdata_o(b_rdata),
    .ready_o(b_ready), .err_o(b_err), .sram_cs_o(b_cs), .sram_we_o(b_we),
    .sram_be_o(b_be), .sram_addr_o(b_saddr), .sram_wdata_o(b_swdata),
    .sram_rdata_i(16'h1234), .dbg_state(b_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one request on DUT A and observe it until ready_o (bounded).
  // With glitch set, a second request to another address is pulsed during ACCESS.
  task automatic access_a(input logic wr, input logic bo, input logic hi,
                          input logic [14:0] addr, input logic [15:0] wd, input logic glitch,
                          output int lat, output int cs_n, output int we_n,
                          output logic [1:0] be, output logic [15:0] rd, output logic er,
                          output logic addr_ok, output logic after_rdy);
    lat = 0; cs_n = 0; we_n = 0; be = 2'b00; rd = '0; er = 1'b0; addr_ok = 1'b1;
    @(posedge clk); #1;
    a_req = 1'b1; a_wr = wr; a_bo = bo; a_hi = hi; a_addr = addr; a_wdata = wd;
    @(posedge clk); #1;
    a_req = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (glitch && k == 1) begin a_req = 1'b1; a_addr = 15'h0020; a_wdata = 16'hDEAD; end
      if (glitch && k == 2) a_req = 1'b0;
      if (a_cs) begin
        cs_n++;
        if (a_we) we_n++;
        be = a_be;
        if (a_saddr !== addr || (wr && a_swdata !== wd)) addr_ok = 1'b0;
      end
      if (a_ready) begin
        lat = k; rd = a_rdata; er = a_err;
        break;
      end
    end
    @(negedge clk);
    after_rdy = a_ready;
  endtask

  int         lat, cs_n, we_n, pulses;
  logic [1:0] be;
  logic [15:0] rd, first_rd;
  logic       er, aok, arz;
  int         pos [0:3];

  initial begin
    repeat (3) @(posedge clk);
    #1; a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    check("rst_ready", a_ready, 0);
    check("rst_outs", {a_err, a_cs, a_we, a_be, a_saddr, a_swdata, a_rdata}, 0);
    check("rst_state", a_dbg, 0);

    // Word write then word read.
    access_a(1, 0, 0, 15'h0010, 16'hBEEF, 0, lat, cs_n, we_n, be, rd, er, aok, arz);
    check("ww_lat", lat, 4);
    check("ww_cs_cycles", cs_n, 3);
    check("ww_we_cycles", we_n, 3);
    check("ww_be", be, 2'b11);
    check("ww_hold", aok, 1);
    check("ww_rd_err", {rd, er}, 17'h0);
    check("ww_pulse_width", arz, 0);

    access_a(0, 0, 0, 15'h0010, 16'h0000, 0, lat, cs_n, we_n, be, rd, er, aok, arz);
    check("wr_lat", lat, 4);
    check("wr_we_cycles", we_n, 0);
    check("wr_data", rd, 16'hBEEF);
    check("wr_err", er, 0);

    // Byte write to high lane, then reads of both views.
    access_a(1, 1, 1, 15'h0010, 16'h5A5A, 0, lat, cs_n, we_n, be, rd, er, aok, arz);
    check("bw_be", be, 2'b10);
    check("bw_lat", lat, 4);
    access_a(0, 0, 0, 15'h0010, 16'h0000, 0, lat, cs_n, we_n, be, rd, er, aok, arz);
    check("bw_word_read", rd, 16'h5AEF);
    access_a(0, 1, 0, 15'h0010, 16'h0000, 0, lat, cs_n, we_n, be, rd, er, aok, arz);
    check("br_lo_be", be, 2'b01);
    check("br_lo_data", rd, 16'h00EF);
    access_a(0, 1, 1, 15'h0010, 16'h0000, 0, lat, cs_n, we_n, be, rd, er, aok, arz);
    check("br_hi_data", rd, 16'h005A);

    // Out-of-range address answers with an error and no SRAM cycle.
    access_a(0, 0, 0, 15'h1000, 16'h0000, 0, lat, cs_n, we_n, be, rd, er, aok, arz);
    check("err_lat", lat, 1);
    check("err_cs_cycles", cs_n, 0);
    check("err_flag", er, 1);
    check("err_data", rd, 0);
    access_a(0, 0, 0, 15'h0FFF, 16'h0000, 0, lat, cs_n, we_n, be, rd, er, aok, arz);
    check("limit_ok_lat", lat, 4);
    check("limit_ok_err", er, 0);

    // Request pulsed mid-access is ignored.
    access_a(0, 0, 0, 15'h0010, 16'h0000, 1, lat, cs_n, we_n, be, rd, er, aok, arz);
    check("ign_lat", lat, 4);
    check("ign_addr", aok, 1);
    check("ign_data", rd, 16'h5AEF);
    check("ign_no_extra", {a_cs, a_ready}, 0);

    // Reset during the second ACCESS cycle of a read.
    @(posedge clk); #1;
    a_req = 1'b1; a_wr = 1'b0; a_bo = 1'b0; a_hi = 1'b0; a_addr = 15'h0010;
    @(posedge clk); #1;
    a_req = 1'b0;
    @(negedge clk);
    check("rst_mid_acc1", a_cs, 1);
    @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    check("rst_mid_state", a_dbg, 0);
    check("rst_mid_outs", {a_ready, a_err, a_cs, a_we, a_be, a_saddr, a_swdata, a_rdata}, 0);
    a_rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (a_ready) pulses++;
    end
    check("rst_mid_no_ready", pulses, 0);
    access_a(0, 0, 0, 15'h0010, 16'h0000, 0, lat, cs_n, we_n, be, rd, er, aok, arz);
    check("rst_fresh_lat", lat, 4);
    check("rst_fresh_data", rd, 16'h5AEF);

    // WAIT=0 with req held high: one response every third cycle.
    @(posedge clk); #1;
    b_req = 1'b1;
    pulses = 0; first_rd = '0;
    for (int k = 0; k < 4; k++) pos[k] = 0;
    @(posedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (b_ready) begin
        if (pulses == 0) first_rd = b_rdata;
        if (pulses < 4) pos[pulses] = k;
        pulses++;
      end
      if (k == 11) b_req = 1'b0;
    end
    check("tp_pulses", pulses, 4);
    check("tp_pos0", pos[0], 2);
    check("tp_pos1", pos[1], 5);
    check("tp_pos2", pos[2], 8);
    check("tp_pos3", pos[3], 11);
    check("tp_rdata", first_rd, 16'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/xm_memory_controller.md
# xm_memory_controller

Memory-side responder for the X-Makina processor memory port. Accepts word/byte read and write requests issued by the datapath (word address from MAR, write data from OMDR, byte-lane select), drives a single-port synchronous SRAM with configurable wait states, steers byte lanes, and returns read data with a one-cycle ready pulse. Out-of-range addresses are answered with an error response instead of an SRAM access.

## Interface
- WORD, 16, data width; word address width is WORD-(WORD/8)+1 = 15
- WAIT, 2, extra SRAM wait cycles per access (0..15)
- ADDR_LIMIT, 15'h7FFF, highest valid word address; above it is a bad access

- clk_i  in  1  system clock, all logic on rising edge
- arst_i  in  1  reset, synchronous, active-high
- req_i  in  1  access request, sampled only in IDLE
- wr_i  in  1  1 = write, 0 = read (sampled with req_i)
- byteOp_i  in  1  1 = byte access, 0 = word access
- byteHi_i  in  1  byte lane for byte access: 1 = bits [15:8], 0 = bits [7:0]
- addr_i  in  15  word address (MAR)
- wdata_i  in  WORD  write data (OMDR; byte writes arrive duplicated in both lanes)
- rdata_o  out  WORD  read data, valid while ready_o = 1
- ready_o  out  1  one-cycle completion pulse
- err_o  out  1  bad-address flag, valid while ready_o = 1
- sram_cs_o  out  1  SRAM chip select
- sram_we_o  out  1  SRAM write enable
- sram_be_o  out  2  SRAM byte enables {hi, lo}
- sram_addr_o  out  15  SRAM word address
- sram_wdata_o  out  WORD  SRAM write data
- sram_rdata_i  in  WORD  SRAM read data, valid one cycle after a cs cycle

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if req_i = 1, latch wr_i, byteOp_i, byteHi_i, addr_i, wdata_i. If addr_i > ADDR_LIMIT -> RESP with error; else -> ACCESS, counter loaded with WAIT.
- ACCESS: sram_cs_o = 1, sram_addr_o/sram_wdata_o from latches, sram_we_o = latched wr. sram_be_o = 2'b11 for word; 2'b10 (byteHi) or 2'b01 for byte. Counter != 0: decrement, stay. Counter == 0: capture read data, -> RESP.
- Read steering: word -> rdata = sram_rdata_i; byte -> rdata = {8'h00, selected lane}.
- RESP: ready_o = 1, rdata_o driven from capture register (0 for writes and errors), err_o = error flag. -> IDLE unconditionally.
- Error response: no SRAM cycle (sram_cs_o stays 0), rdata_o = 0, err_o = 1.
- req_i in ACCESS/RESP is ignored; requester re-issues after ready_o.
- Outside ACCESS all sram_* outputs are 0.

## Timing
- Reset: state IDLE, counter 0, all latches 0; ready_o, err_o, rdata_o, sram_cs_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o all 0. Reset mid-access: following cycle is IDLE with all outputs 0, no ready_o pulse; in-flight SRAM write may or may not have completed.
- Valid access latency: req_i sampled at edge 0 -> ACCESS cycles 1..WAIT+1 -> ready_o high in cycle WAIT+2 for exactly one cycle.
- Error latency: ready_o high in cycle 1.
- Earliest next request sampled in the cycle after RESP (IDLE); back-to-back throughput one access per WAIT+3 cycles.
- Read data captured on last ACCESS edge; rdata_o stable only during ready_o.
- Write held for WAIT+1 cycles with identical address/data/be (repeated writes are idempotent).

## Structure
- Package xm_mem_pkg: state enum (IDLE, ACCESS, RESP), byte-enable constants BE_WORD = 2'b11, BE_HI = 2'b10, BE_LO = 2'b01, address-width localparam derived from WORD.
- Sub-module xm_wait_counter: 4-bit loadable down-counter with load, enable, zero flag; instantiated once.
- FSM, latches and lane steering stay in xm_memory_controller.

## Test plan
- WAIT=2: word write 16'hBEEF to 15'h0010, then word read 15'h0010 -> cs/we high 3 cycles, be=11; ready_o in cycle 4; rdata_o = 16'hBEEF, err_o = 0.
- Byte write 8'h5A high lane (wdata 16'h5A5A) to 15'h0010, then word read -> be = 10; rdata_o = 16'h5AEF; byte read low lane -> 16'h00EF.
- ADDR_LIMIT=15'h0FFF, read 15'h1000 -> sram_cs_o never high; ready_o in cycle 1, err_o = 1, rdata_o = 0.
- WAIT=0, req_i held high continuously for four reads -> ready_o every 3rd cycle, exactly four pulses.
- req_i pulsed again with different address during ACCESS -> ignored; original access completes with original address/data.
- arst_i asserted during second ACCESS cycle of a read -> next cycle IDLE, all outputs 0, no ready_o; fresh request afterwards completes normally.
